mxn_rr_sel: RTL

Parametrised successor to the 4-bit 2:1 mux: an N-channel, WIDTH-bit selector that arbitrates round-robin between requesting channels and delivers the winner through a registered valid/ready output stage. Sits between multiple producer blocks and one shared consumer in the datapath. It replaces static select-line multiplexing wherever sources are independent and may request at the same time.

---
 rtl/mxn_rr_sel_if.sv | 39 +++
 rtl/mxn_rr_sel.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mxn_rr_sel_if.sv
// Handshake bundle for mxn_rr_sel: N request channels in, one registered word out.
// Ports: in_valid/in_data/in_ready (producer side), out_valid/out_data/out_sel/out_ready (consumer side).
`timescale 1ns/1ps

interface mxn_rr_sel_if #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int SW    = $clog2(N)
);
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_sel;
    logic               out_ready;

    // Environment view: drives requests and the consumer ready.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel,
        output out_ready
    );

    // Selector view.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel,
        input  out_ready
    );
endinterface

// File: rtl/mxn_rr_sel.sv
// N-channel WIDTH-bit round-robin selector with a registered valid/ready output.
// Ports: clk, reset_n (async, active-low), bus (mxn_rr_sel_if.slave). Macro: MXN_RR_SEL_FIXED_PRI_EN.
`timescale 1ns/1ps

module mxn_rr_sel #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int SW    = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    mxn_rr_sel_if.slave  bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            load_ok;
    logic            any_req;
    logic            accept;
    logic [N-1:0]    grant;
    logic [SW-1:0]   gidx;
    logic [SW-1:0]   base;
    logic [SW:0]     idx_full;
    logic [SW-1:0]   idx;
    logic [WIDTH-1:0] data_q;
    logic [SW-1:0]   sel_q;

`ifdef MXN_RR_SEL_FIXED_PRI_EN
    // No rotating pointer: the search always begins at channel 0.
    assign base = '0;
`else
    logic [SW-1:0]   ptr_q;

    assign base = ptr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (accept) begin
            if (gidx == SW'(N - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= gidx + 1'b1;
            end
        end
    end
`endif

    // First requester at or above base, wrapping past N-1 back to 0.
    always_comb begin
        grant    = '0;
        gidx     = '0;
        any_req  = 1'b0;
        idx_full = '0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx_full = {1'b0, base} + (SW+1)'(k);
            if (idx_full >= (SW+1)'(N)) begin
                idx_full = idx_full - (SW+1)'(N);
            end
            idx = idx_full[SW-1:0];
            if (!any_req && bus.in_valid[idx]) begin
                any_req     = 1'b1;
                gidx        = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

    assign load_ok = (state_q == EMPTY) || bus.out_ready;
    assign accept  = load_ok && any_req;

    // Masked by reset so no channel sees a handshake while held in reset.
    assign bus.in_ready = (load_ok && reset_n) ? grant : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                // Drain and reload on the same edge keeps the register full.
                if (accept) begin
                    state_d = FULL;
                end else if (bus.out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            sel_q  <= '0;
        end else if (accept) begin
            data_q <= bus.in_data[int'(gidx)*WIDTH +: WIDTH];
            sel_q  <= gidx;
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

endmodule
